// File: rtl/eth_frame_builder_pkg.sv
// Shared constants, FSM state type and ones-complement arithmetic for the
// Ethernet/IPv4/UDP frame builder.
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam int unsigned HDR_LEN        = 42;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSUM,
    S_HDR,
    S_PAYLOAD,
    S_PAD,
    S_START,
    S_WAIT
  } state_e;

  // 16-bit ones-complement add: 17-bit sum with the carry folded back in.
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/eth_frame_builder_ip_csum.sv
// Sequential IPv4 header checksum accumulator, one 16-bit word per cycle.
module ip_csum
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        word_valid,
  input  logic [15:0] word,
  output logic [15:0] sum
);

  logic [15:0] sum_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
    end else if (word_valid) begin
      sum_q <= ones_add(sum_q, word);
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/eth_frame_builder.sv
// Builds an Ethernet II / IPv4 / UDP frame (no FCS) into the tx BRAM, pads
// runts to MIN_FRAME, then hands the frame length to the transmitter.
module eth_frame_builder
  import eth_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 982,
  parameter int unsigned MIN_FRAME   = 60,
  parameter int unsigned IP_TTL      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] src_mac,
  input  logic [47:0] dst_mac,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic        req_valid,
  input  logic [10:0] req_len,
  output logic        req_ready,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic        drop_stb,
  output logic        bram_wr_en,
  output logic [9:0]  bram_wr_addr,
  output logic [7:0]  bram_wr_data,
  output logic        start_stb,
  output logic [10:0] tx_len,
  input  logic        tx_busy
);

  state_e      state_q, state_d;
  logic [47:0] dst_mac_q, src_mac_q;
  logic [31:0] src_ip_q, dst_ip_q;
  logic [15:0] src_port_q, dst_port_q;
  logic [10:0] len_q;
  logic [15:0] id_q;
  logic [9:0]  addr_q, addr_d;
  logic [10:0] tx_len_q, tx_len_d;
  logic        drop_q, drop_d;

  logic        accept, latch, too_long, id_inc, csum_clr, csum_vld;
  logic        need_pad, pl_last, wr_en, req_rdy, pl_rdy;
  logic [15:0] csum_word, csum_sum, ip_len, udp_len;
  logic [10:0] frame_len, tx_len_final;
  logic [7:0]  wr_data, hdr_byte;
  logic [335:0] hdr_vec, hdr_sh;

  assign too_long     = req_len > 11'(MAX_PAYLOAD);
  assign accept       = req_valid && req_rdy;
  assign frame_len    = 11'(HDR_LEN) + len_q;
  assign need_pad     = frame_len < 11'(MIN_FRAME);
  assign tx_len_final = need_pad ? 11'(MIN_FRAME) : frame_len;
  assign pl_last      = ({1'b0, addr_q} == frame_len - 11'd1);
  assign ip_len       = 16'd28 + {5'd0, len_q};
  assign udp_len      = 16'd8 + {5'd0, len_q};

  always_comb begin
    csum_word = '0;
    case (addr_q)
      10'd0:   csum_word = 16'h4500;
      10'd1:   csum_word = ip_len;
      10'd2:   csum_word = id_q;
      10'd3:   csum_word = 16'h4000;
      10'd4:   csum_word = {8'(IP_TTL), IP_PROTO_UDP};
      10'd5:   csum_word = src_ip_q[31:16];
      10'd6:   csum_word = src_ip_q[15:0];
      10'd7:   csum_word = dst_ip_q[31:16];
      10'd8:   csum_word = dst_ip_q[15:0];
      default: csum_word = '0;
    endcase
  end

  ip_csum u_csum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (csum_clr),
    .word_valid (csum_vld),
    .word       (csum_word),
    .sum        (csum_sum)
  );

  // Header laid out MSB-first; addr_q selects the byte by shifting it to the top.
  assign hdr_vec = {dst_mac_q, src_mac_q, ETHERTYPE_IPV4, 8'h45, 8'h00, ip_len, id_q,
                    8'h40, 8'h00, 8'(IP_TTL), IP_PROTO_UDP, ~csum_sum,
                    src_ip_q, dst_ip_q, src_port_q, dst_port_q, udp_len, 16'h0000};
  assign hdr_sh   = hdr_vec << {addr_q, 3'b000};
  assign hdr_byte = hdr_sh[335:328];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    tx_len_d = tx_len_q;
    drop_d   = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    req_rdy  = 1'b0;
    pl_rdy   = 1'b0;
    csum_clr = 1'b0;
    csum_vld = 1'b0;
    id_inc   = 1'b0;
    latch    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_rdy = !tx_busy && rst_n;
        if (accept) begin
          latch = 1'b1;
          if (too_long) begin
            drop_d = 1'b1;
          end else begin
            state_d  = S_CSUM;
            addr_d   = '0;
            csum_clr = 1'b1;
          end
        end
      end
      S_CSUM: begin
        csum_vld = 1'b1;
        addr_d   = addr_q + 10'd1;
        if (addr_q == 10'd8) begin
          state_d = S_HDR;
          addr_d  = '0;
        end
      end
      S_HDR: begin
        wr_en   = 1'b1;
        wr_data = hdr_byte;
        addr_d  = addr_q + 10'd1;
        if (addr_q == 10'(HDR_LEN - 1)) begin
          if (len_q != '0) state_d = S_PAYLOAD;
          else if (need_pad) state_d = S_PAD;
          else state_d = S_START;
        end
      end
      S_PAYLOAD: begin
        pl_rdy = 1'b1;
        if (pl_valid) begin
          wr_en   = 1'b1;
          wr_data = pl_data;
          addr_d  = addr_q + 10'd1;
          if (pl_last) state_d = need_pad ? S_PAD : S_START;
        end
      end
      S_PAD: begin
        wr_en  = 1'b1;
        addr_d = addr_q + 10'd1;
        if (addr_q == 10'(MIN_FRAME - 1)) state_d = S_START;
      end
      S_START: begin
        // Held until the transmitter acknowledges by raising tx_busy.
        if (tx_busy) begin
          state_d = S_WAIT;
          id_inc  = 1'b1;
        end
      end
      S_WAIT: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_START) tx_len_d = tx_len_final;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      tx_len_q   <= '0;
      drop_q     <= 1'b0;
      id_q       <= '0;
      len_q      <= '0;
      dst_mac_q  <= '0;
      src_mac_q  <= '0;
      src_ip_q   <= '0;
      dst_ip_q   <= '0;
      src_port_q <= '0;
      dst_port_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      tx_len_q <= tx_len_d;
      drop_q   <= drop_d;
      if (id_inc) id_q <= id_q + 16'd1;
      if (latch) begin
        len_q      <= req_len;
        dst_mac_q  <= dst_mac;
        src_mac_q  <= src_mac;
        src_ip_q   <= src_ip;
        dst_ip_q   <= dst_ip;
        src_port_q <= src_port;
        dst_port_q <= dst_port;
      end
    end
  end

  assign req_ready    = req_rdy;
  assign pl_ready     = pl_rdy;
  assign drop_stb     = drop_q;
  assign bram_wr_en   = wr_en;
  assign bram_wr_addr = wr_en ? addr_q : '0;
  assign bram_wr_data = wr_data;
  assign start_stb    = (state_q == S_START);
  assign tx_len       = tx_len_q;

endmodule

// File: tb/tb_eth_frame_builder.sv
// Directed + randomized bench for eth_frame_builder with a byte-array frame model.
module tb_eth_frame_builder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] src_mac = '0, dst_mac = '0;
  logic [31:0] src_ip = '0, dst_ip = '0;
  logic [15:0] src_port = '0, dst_port = '0;
  logic        req_valid = 1'b0;
  logic [10:0] req_len = '0;
  logic        req_ready;
  logic [7:0]  pl_data = '0;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic        drop_stb;
  logic        bram_wr_en;
  logic [9:0]  bram_wr_addr;
  logic [7:0]  bram_wr_data;
  logic        start_stb;
  logic [10:0] tx_len;
  logic        tx_busy = 1'b0;

  always #5 clk = ~clk;

  eth_frame_builder #(.MAX_PAYLOAD(982), .MIN_FRAME(60), .IP_TTL(64)) dut (
    .clk(clk), .rst_n(rst_n), .src_mac(src_mac), .dst_mac(dst_mac),
    .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port),
    .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .drop_stb(drop_stb), .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr),
    .bram_wr_data(bram_wr_data), .start_stb(start_stb), .tx_len(tx_len),
    .tx_busy(tx_busy)
  );

  int total = 0;
  int bad = 0;

  // BRAM recorder
  logic [7:0] mem [0:1023];
  int wr_cnt = 0, seq_err = 0, nv_wr = 0, last_addr = -1;
  always @(posedge clk) begin
    if (bram_wr_en) begin
      mem[bram_wr_addr] <= bram_wr_data;
      wr_cnt <= wr_cnt + 1;
      if (int'(bram_wr_addr) != 0 && int'(bram_wr_addr) != last_addr + 1) seq_err <= seq_err + 1;
      last_addr <= int'(bram_wr_addr);
      if (pl_ready && !pl_valid) nv_wr <= nv_wr + 1;
    end
  end

  // Reference model state
  logic [47:0] m_dst, m_src;
  logic [31:0] m_sip, m_dip;
  logic [15:0] m_sp, m_dp;
  int          m_len;
  int          m_id = 0;
  logic [7:0]  m_pl [0:1023];
  logic [7:0]  exp_q [$];
  int wr_base, seq_base, nv_base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_csum();
    int unsigned s;
    s = 32'h4500 + 32'(28 + m_len) + 32'(m_id) + 32'h4000 + 32'h4011
      + 32'(m_sip[31:16]) + 32'(m_sip[15:0]) + 32'(m_dip[31:16]) + 32'(m_dip[15:0]);
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  task automatic push16(input logic [15:0] v);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
  endtask

  task automatic build_expected();
    logic [15:0] cs;
    cs = ref_csum();
    exp_q.delete();
    for (int i = 5; i >= 0; i--) exp_q.push_back(m_dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(m_src[8*i +: 8]);
    push16(16'h0800);
    push16(16'h4500);
    push16(16'(28 + m_len));
    push16(16'(m_id));
    push16(16'h4000);
    push16(16'h4011);
    push16(cs);
    push16(m_sip[31:16]); push16(m_sip[15:0]);
    push16(m_dip[31:16]); push16(m_dip[15:0]);
    push16(m_sp); push16(m_dp);
    push16(16'(8 + m_len));
    push16(16'h0000);
    for (int i = 0; i < m_len; i++) exp_q.push_back(m_pl[i]);
    while (exp_q.size() < 60) exp_q.push_back(8'h00);
  endtask

  task automatic rand_fields();
    dst_mac  = {16'($urandom), $urandom};
    src_mac  = {16'($urandom), $urandom};
    src_ip   = $urandom;
    dst_ip   = $urandom;
    src_port = 16'($urandom);
    dst_port = 16'($urandom);
  endtask

  task automatic rand_payload(input int len);
    for (int i = 0; i < len; i++) m_pl[i] = 8'($urandom);
  endtask

  task automatic send_req(input int len);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_len   = 11'(len);
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    chk("req_accept", {63'd0, req_ready}, 64'd1);
    m_dst = dst_mac; m_src = src_mac; m_sip = src_ip; m_dip = dst_ip;
    m_sp = src_port; m_dp = dst_port; m_len = len;
    wr_base = wr_cnt; seq_base = seq_err; nv_base = nv_wr;
    @(negedge clk);
    req_valid = 1'b0;
    rand_fields();
  endtask

  task automatic feed(input int len, input bit alternate);
    int k, cyc;
    logic rdy;
    k = 0; cyc = 0;
    while (k < len && cyc < 5000) begin
      pl_valid = alternate ? cyc[0] : ($urandom_range(0, 3) != 0);
      pl_data  = m_pl[k];
      rdy      = pl_ready;
      @(negedge clk);
      cyc++;
      if (pl_valid && rdy) k++;
    end
    pl_valid = 1'b0;
    chk("payload_done", 64'(k), 64'(len));
  endtask

  task automatic check_frame();
    int n, exp_n, mism;
    n = 0;
    while (!start_stb && n < 200) begin @(negedge clk); n++; end
    chk("start_seen", {63'd0, start_stb}, 64'd1);
    exp_n = (42 + m_len < 60) ? 60 : 42 + m_len;
    chk("tx_len", 64'(tx_len), 64'(exp_n));
    chk("wr_count", 64'(wr_cnt - wr_base), 64'(exp_n));
    chk("addr_seq", 64'(seq_err - seq_base), 64'd0);
    chk("last_addr", 64'(last_addr), 64'(exp_n - 1));
    chk("no_write_invalid", 64'(nv_wr - nv_base), 64'd0);
    build_expected();
    mism = 0;
    for (int i = 0; i < exp_n; i++) if (mem[i] !== exp_q[i]) mism++;
    chk("frame_bytes", 64'(mism), 64'd0);
  endtask

  task automatic tx_hs(input int busy, input int next_len);
    int rr;
    logic [10:0] len_hold;
    len_hold = tx_len;
    repeat (4) @(negedge clk);
    chk("start_held", {63'd0, start_stb}, 64'd1);
    tx_busy = 1'b1;
    @(negedge clk);
    chk("start_drop", {63'd0, start_stb}, 64'd0);
    m_id = (m_id + 1) & 16'hFFFF;
    if (next_len >= 0) begin
      rand_fields();
      req_valid = 1'b1;
      req_len   = 11'(next_len);
    end
    rr = 0;
    repeat (busy) begin
      @(negedge clk);
      if (req_ready) rr++;
    end
    chk("ready_low_busy", 64'(rr), 64'd0);
    chk("tx_len_stable", 64'(tx_len), 64'(len_hold));
    tx_busy = 1'b0;
    #1;
    chk("ready_not_same_cycle", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    chk("ready_idle", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    int n, st, wb, ln;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({req_ready, pl_ready, drop_stb, bram_wr_en, start_stb,
                              bram_wr_addr, bram_wr_data, tx_len}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {63'd0, req_ready}, 64'd1);

    // Exact 60-byte frame
    dst_mac = 48'hFFFF_FFFF_FFFF; src_mac = 48'h0200_0000_0001;
    src_ip = 32'h0A00_0001; dst_ip = 32'h0A00_00FF;
    src_port = 16'd1234; dst_port = 16'd5678;
    for (int i = 0; i < 18; i++) m_pl[i] = 8'(i);
    send_req(18);
    feed(18, 1'b0);
    check_frame();
    chk("ip_len_bytes", 64'({mem[16], mem[17]}), 64'h002E);
    chk("udp_len_bytes", 64'({mem[38], mem[39]}), 64'h001A);
    chk("tx_len_60", 64'(tx_len), 64'd60);
    tx_hs(10, -1);

    // Runt frame, padded
    rand_fields(); rand_payload(5);
    send_req(5);
    feed(5, 1'b0);
    check_frame();
    n = 0;
    for (int i = 47; i < 60; i++) if (mem[i] !== 8'h00) n++;
    chk("pad_zero", 64'(n), 64'd0);
    tx_hs(3, -1);

    // Oversize request dropped
    wb = wr_cnt;
    req_valid = 1'b1; req_len = 11'd983;
    @(negedge clk);
    req_valid = 1'b0;
    chk("drop_pulse", {63'd0, drop_stb}, 64'd1);
    @(negedge clk);
    chk("drop_single", {63'd0, drop_stb}, 64'd0);
    chk("drop_ready", {63'd0, req_ready}, 64'd1);
    repeat (20) @(negedge clk);
    chk("drop_no_writes", 64'(wr_cnt - wb), 64'd0);

    // Maximum payload with gapped valid, then back-to-back request
    rand_fields(); rand_payload(982);
    send_req(982);
    feed(982, 1'b1);
    check_frame();
    chk("tx_len_max", 64'(tx_len), 64'd1024);
    ln = $urandom_range(20, 40);
    tx_hs(100, ln);
    rand_payload(ln);
    send_req(ln);
    feed(ln, 1'b0);
    check_frame();
    tx_hs(5, -1);

    // Randomized frames
    for (int r = 0; r < 4; r++) begin
      ln = $urandom_range(0, 80);
      rand_fields(); rand_payload(ln);
      send_req(ln);
      feed(ln, 1'b0);
      check_frame();
      tx_hs($urandom_range(1, 20), -1);
    end

    // Reset during payload aborts the frame
    rand_fields(); rand_payload(30);
    send_req(30);
    n = 0;
    while (!pl_ready && n < 200) begin @(negedge clk); n++; end
    repeat (5) begin
      pl_valid = 1'b1; pl_data = 8'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 64'({req_ready, pl_ready, drop_stb, bram_wr_en, start_stb,
                              bram_wr_addr, bram_wr_data, tx_len}), 64'd0);
    rst_n = 1'b1;
    m_id = 0;
    wb = wr_cnt; st = 0;
    repeat (60) begin
      pl_valid = $urandom_range(0, 1) != 0;
      @(negedge clk);
      if (start_stb) st++;
    end
    pl_valid = 1'b0;
    chk("abort_no_start", 64'(st), 64'd0);
    chk("abort_no_writes", 64'(wr_cnt - wb), 64'd0);
    rand_fields(); rand_payload(12);
    send_req(12);
    feed(12, 1'b0);
    check_frame();
    tx_hs(2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_frame_builder.md
Name: eth_frame_builder

Overview:
- Upstream of the 10BASE-T Manchester transmitter.
- Takes a UDP payload length request plus a byte stream, and writes a complete Ethernet II / IPv4 / UDP frame (no FCS) into the shared 1 KiB tx BRAM.
- Computes the IPv4 header checksum and pads runt frames to 60 bytes.
- Then launches the transmitter via start_stb/tx_len and holds off new requests until tx_busy drops.

Parameters:
- MAX_PAYLOAD, 982, largest accepted UDP payload in bytes (1024 minus 42-byte header).
- MIN_FRAME, 60, minimum frame length before FCS; shorter frames are zero-padded.
- IP_TTL, 64, TTL byte placed in the IPv4 header.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- src_mac  in  48  source MAC, sampled at request accept
- dst_mac  in  48  destination MAC, sampled at request accept
- src_ip  in  32  source IPv4, sampled at accept
- dst_ip  in  32  destination IPv4, sampled at accept
- src_port  in  16  UDP source port, sampled at accept
- dst_port  in  16  UDP destination port, sampled at accept
- req_valid  in  1  frame request
- req_len  in  11  UDP payload byte count
- req_ready  out  1  request accepted when req_valid & req_ready
- pl_data  in  8  payload byte
- pl_valid  in  1  payload byte valid
- pl_ready  out  1  payload byte consumed when pl_valid & pl_ready
- drop_stb  out  1  one-cycle pulse: request rejected (req_len > MAX_PAYLOAD)
- bram_wr_en  out  1  BRAM write strobe
- bram_wr_addr  out  10  BRAM write address
- bram_wr_data  out  8  BRAM write data
- start_stb  out  1  transmit request to transmitter (level, held)
- tx_len  out  11  frame length in bytes excluding FCS
- tx_busy  in  1  transmitter busy

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset: all outputs 0; state IDLE; IPv4 identification counter = 0.
- Reset mid-frame aborts: the partial BRAM contents are left as-is and never transmitted.

State machine:
- IDLE:
  - req_ready = !tx_busy.
  - On accept, latch addresses, ports and req_len.
  - If req_len > MAX_PAYLOAD: pulse drop_stb, stay IDLE, no BRAM writes, id not incremented.
  - Otherwise go to CSUM.
- CSUM: 9 cycles, one 16-bit word per cycle, 17-bit add with end-around carry.
  - Words in order: 0x4500, ip_len = 28+len, id, 0x4000, {IP_TTL, 0x11}, src_ip hi, src_ip lo, dst_ip hi, dst_ip lo.
  - Checksum = ~sum[15:0].
  - Go to HDR.
- HDR: 42 cycles, one byte per cycle, addresses 0..41, all fields big-endian:
  - dst_mac, src_mac, ethertype 0x0800
  - IPv4 header: 0x45 0x00, ip_len, id, 0x40 0x00, TTL, 0x11, checksum, src_ip, dst_ip
  - UDP header: src_port, dst_port, udp_len = 8+len, checksum 0x0000
  - Go to PAYLOAD, or directly to PAD/START if len = 0.
- PAYLOAD:
  - pl_ready = 1. Each handshake writes pl_data at addr 42+k.
  - pl_valid low stalls indefinitely with no write.
  - After len bytes: go to PAD if 42+len < MIN_FRAME, else START.
- PAD: write 0x00 at addr 42+len .. MIN_FRAME-1, one per cycle. Then START.
- START:
  - tx_len = max(MIN_FRAME, 42+len).
  - start_stb = 1, held until tx_busy is seen high, because the transmitter samples only on its bit strobe.
  - Then deassert start_stb, increment id (wraps 0xFFFF→0), go to WAIT.
- WAIT: on tx_busy = 0, return to IDLE.

Write and handshake rules:
- bram_wr_en is high only in HDR, PAYLOAD (on handshake) and PAD.
- Address increments by exactly 1 per write.
- Maximum address is 1023 (len = 982, reached in PAYLOAD).
- pl_ready = 0 in all states except PAYLOAD.
- req_ready = 0 in all states except IDLE.
- tx_len is held stable from START until the next accept.
- A request is accepted no earlier than the cycle after tx_busy falls.

Decomposition:
- Shared package eth_pkg:
  - ETHERTYPE_IPV4 = 0x0800, IP_PROTO_UDP = 0x11, HDR_LEN = 42
  - state enum
  - ones-complement add function
- One natural sub-module: ip_csum (sequential 16-bit ones-complement accumulator).
  - Ports: clr, word_valid, word, sum.

Test Plan:
- len=18, dst_mac=FF:FF:FF:FF:FF:FF, src_mac=02:00:00:00:00:01, 10.0.0.1→10.0.0.255, ports 1234→5678, payload 0x00..0x11 -> 60 bytes written, no padding needed (42+18 = 60). Expect bytes 16-17 = 0x002E, udp_len = 0x001A, ip checksum matches reference model, tx_len = 60, start_stb held until tx_busy.
- len=5 -> bytes 47..59 = 0x00, tx_len = 60, final bram_wr_addr = 59.
- len=982 with pl_valid toggling every other cycle -> exactly 982 payload writes, last addr 1023, tx_len = 1024, no write while pl_valid = 0.
- len=983 -> drop_stb single pulse, zero BRAM writes, req_ready stays high, id unchanged.
- Two back-to-back requests, tx_busy held high for 100 cycles after start -> second req_ready stays low until tx_busy falls; ids 0 then 1; checksums differ accordingly.
- rst_n low during PAYLOAD -> next cycle all outputs 0, state IDLE, start_stb never asserted for the aborted frame.
